control_campos_configuracion: RTL
=================================

// Module: control_campos_configuracion
// PURPOSE
//  Front end of the RTC configuration path. Debounces the four raw pushbuttons and
//  tracks which field is being edited. Drives the shared en_count/enUP/enDOWN bus
//  read by every field counter (field 7 = day-of-week counter).
//  Downstream counters edge-detect enUP/enDOWN themselves, so this block drives clean levels.
// PARAMETERS
//  DEBOUNCE_CYCLES  16'd50000  consecutive stable cycles before a debounced level changes (>=2)
//  NUM_FIELDS       4'd9       number of editable fields; en_count codes 1..NUM_FIELDS (<=15)
//  HOLD_CYCLES      32'd50000000  hold time before auto-repeat starts (AUTOREPEAT_EN only)
//  REPEAT_CYCLES    32'd10000000  auto-repeat period (AUTOREPEAT_EN only, >=2)
// PORTS
//  clk          in   1  system clock
//  reset        in   1  synchronous, active-high reset
//  config_mode  in   1  level; 1 = configuration mode active (already synchronous)
//  btn_up       in   1  raw asynchronous pushbutton, active-high
//  btn_down     in   1  raw asynchronous pushbutton, active-high
//  btn_left     in   1  raw asynchronous pushbutton, active-high
//  btn_right    in   1  raw asynchronous pushbutton, active-high
//  en_count     out  4  selected field; 0 = none
//  enUP         out  1  increment request level for the selected field
//  enDOWN       out  1  decrement request level for the selected field
// BEHAVIOUR
//  - Single clock domain. Reset is synchronous and active-high.
//  - Reset: en_count=0, enUP=0, enDOWN=0, FSM=IDLE. All sync/debounce flops and counters are 0.
//    Reset mid-operation aborts everything on the same edge.
//  - Input path, per button: 2-flop synchronizer s1->s2, then debounced level db.
//    - Counter cnt increments each cycle that s2!=db and clears when s2==db.
//    - When s2!=db and cnt==DEBOUNCE_CYCLES-1: db<=s2 and cnt<=0.
//    - Net effect: db changes on the 2+DEBOUNCE_CYCLES-th edge after a stable raw change.
//    - Glitches shorter than DEBOUNCE_CYCLES cycles never reach db.
//  - A press is a db 0->1 transition: a 1-cycle internal pulse; release is ignored.
//  - All outputs are registered: +1 cycle after db/press.
//  - FSM IDLE:
//    - en_count=0; enUP=enDOWN=0; buttons are ignored.
//    - config_mode=1 -> EDIT, field=1.
//  - FSM EDIT:
//    - en_count=field.
//    - right press: field+1, NUM_FIELDS wraps to 1.
//    - left press: field-1, 1 wraps to NUM_FIELDS.
//    - left and right pressed on the same cycle: both ignored.
//    - left/right presses are ignored while enUP or enDOWN is 1 (no field change mid-edit).
//    - config_mode=0 -> IDLE: en_count=0 and enUP=enDOWN=0 on the next edge,
//      regardless of button state.
//  - Up/down arbitration in EDIT:
//    - enUP follows db_up and enDOWN follows db_down.
//    - Never both high. Whichever asserted first owns the bus.
//    - The other stays 0 until both debounced levels are 0.
//    - Simultaneous assertion: neither is driven until both are released.
//  - Entering EDIT while up/down are already held does not assert enUP/enDOWN;
//    a fresh press is required.
// CONFIGURATION
//  AUTOREPEAT_EN defined: the owning direction auto-repeats while it stays held.
//    - After it has been 1 for HOLD_CYCLES cycles, the output goes low for exactly 1 cycle,
//      then high again.
//    - The 1-cycle low repeats every REPEAT_CYCLES cycles while the button stays held.
//    - Hold/repeat counters clear on release, on field change and on leaving EDIT.
//  AUTOREPEAT_EN undefined: enUP/enDOWN are plain arbitrated levels, with one edge per press.
//    No hold/repeat logic is synthesized; HOLD_CYCLES and REPEAT_CYCLES are unused.
// TESTING (bench: DEBOUNCE_CYCLES=4, NUM_FIELDS=9, HOLD_CYCLES=20, REPEAT_CYCLES=8)
//  1 reset held 3 cycles, all buttons toggling -> en_count=0, enUP=0, enDOWN=0 throughout.
//  2 config_mode=1, then 3 clean right presses.
//    -> en_count 1,2,3,4; 9 right presses from 1 wraps back to 1; one left press from 1 -> 9.
//  3 btn_up raw 1 held, field=7.
//    -> enUP=1 on the 7th edge (2 sync + 4 debounce + 1 output) after the raw rise.
//    A 3-cycle glitch on btn_up gives enUP=0.
//  4 up held, then down pressed -> enDOWN stays 0.
//    Up and down asserted together -> neither asserts until both are released.
//  5 right pressed while enUP=1 -> field unchanged.
//    config_mode drops while up is held -> next edge en_count=0, enUP=0.
//  6 AUTOREPEAT_EN: up held 60 cycles.
//    -> enUP 1-cycle low pulses at 20, 28, 36, 44, 52 cycles after enUP rises.
//    Without the macro -> enUP constant 1.

Source files
------------

// File: rtl/control_campos_configuracion.sv
`default_nettype none
// ============================================================================
// Module  : control_campos_configuracion
// Brief   : RTC configuration front end. Debounces the four pushbuttons, walks
//           the edited field and drives the arbitrated enUP/enDOWN levels.
//           Optional auto-repeat of the held direction: define AUTOREPEAT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module control_campos_configuracion #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [3:0]  NUM_FIELDS      = 4'd9,
  parameter logic [31:0] HOLD_CYCLES     = 32'd50000000,
  parameter logic [31:0] REPEAT_CYCLES   = 32'd10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       config_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [3:0] en_count,
  output logic       enUP,
  output logic       enDOWN
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EDIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    ARB_FREE = 2'd0,
    ARB_UP   = 2'd1,
    ARB_DOWN = 2'd2,
    ARB_LOCK = 2'd3
  } arb_t;

  localparam int C_NUM_BTN = 4;

  logic [C_NUM_BTN-1:0] w_raw;
  logic [C_NUM_BTN-1:0] w_db;
  logic [C_NUM_BTN-1:0] w_press;

  assign w_raw = {btn_right, btn_left, btn_down, btn_up};

  genvar gi;
  generate
    for (gi = 0; gi < C_NUM_BTN; gi++) begin : g_btn
      logic        r_s1;
      logic        r_s2;
      logic        r_db;
      logic        r_db_q;
      logic [15:0] r_cnt;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_s1   <= 1'b0;
          r_s2   <= 1'b0;
          r_db   <= 1'b0;
          r_db_q <= 1'b0;
          r_cnt  <= 16'd0;
        end else begin
          r_s1   <= w_raw[gi];
          r_s2   <= r_s1;
          r_db_q <= r_db;
          if (r_s2 != r_db) begin
            if (r_cnt == DEBOUNCE_CYCLES - 16'd1) begin
              r_db  <= r_s2;
              r_cnt <= 16'd0;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end else begin
            r_cnt <= 16'd0;
          end
        end
      end

      assign w_db[gi]    = r_db;
      assign w_press[gi] = r_db & ~r_db_q;
    end
  endgenerate

  logic w_db_up, w_db_dn, w_pr_up, w_pr_dn, w_pr_left, w_pr_right;
  assign w_db_up    = w_db[0];
  assign w_db_dn    = w_db[1];
  assign w_pr_up    = w_press[0];
  assign w_pr_dn    = w_press[1];
  assign w_pr_left  = w_press[2];
  assign w_pr_right = w_press[3];

  state_t     r_state, w_state_nx;
  arb_t       r_arb, w_arb_nx;
  logic [3:0] r_field, w_field_nx;
  logic       w_busy;
  logic       w_gap;

  always_comb begin
    w_state_nx = r_state;
    w_field_nx = r_field;
    w_arb_nx   = r_arb;
    w_busy     = (r_arb == ARB_UP) || (r_arb == ARB_DOWN);
    case (r_state)
      ST_IDLE: begin
        w_arb_nx = ARB_FREE;
        if (config_mode) begin
          w_state_nx = ST_EDIT;
          w_field_nx = 4'd1;
          // Buttons already held on entry must be released before they count.
          w_arb_nx   = (w_db_up || w_db_dn) ? ARB_LOCK : ARB_FREE;
        end
      end
      ST_EDIT: begin
        if (!config_mode) begin
          w_state_nx = ST_IDLE;
          w_arb_nx   = ARB_FREE;
        end else begin
          if (!w_busy && (w_pr_left ^ w_pr_right)) begin
            if (w_pr_right) begin
              w_field_nx = (r_field >= NUM_FIELDS) ? 4'd1 : r_field + 4'd1;
            end else begin
              w_field_nx = (r_field <= 4'd1) ? NUM_FIELDS : r_field - 4'd1;
            end
          end
          case (r_arb)
            ARB_FREE: begin
              if (w_pr_up && w_pr_dn) w_arb_nx = ARB_LOCK;
              else if (w_pr_up)       w_arb_nx = ARB_UP;
              else if (w_pr_dn)       w_arb_nx = ARB_DOWN;
            end
            ARB_UP: begin
              if (!w_db_up) w_arb_nx = w_db_dn ? ARB_LOCK : ARB_FREE;
            end
            ARB_DOWN: begin
              if (!w_db_dn) w_arb_nx = w_db_up ? ARB_LOCK : ARB_FREE;
            end
            default: begin
              if (!w_db_up && !w_db_dn) w_arb_nx = ARB_FREE;
            end
          endcase
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_arb_nx   = ARB_FREE;
      end
    endcase
  end

`ifdef AUTOREPEAT_EN
  logic [31:0] r_rpt_cnt;
  logic        r_rpt_phase;
  logic        w_rpt_run;
  logic        w_rpt_wrap;

  // The count advances only while the same direction keeps ownership in EDIT.
  assign w_rpt_run  = (w_state_nx == ST_EDIT) && w_busy && (w_arb_nx == r_arb);
  assign w_rpt_wrap = r_rpt_phase ? (r_rpt_cnt == REPEAT_CYCLES - 32'd1)
                                  : (r_rpt_cnt == HOLD_CYCLES - 32'd1);
  assign w_gap      = w_rpt_run && w_rpt_wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rpt_cnt   <= 32'd0;
      r_rpt_phase <= 1'b0;
    end else if (!w_rpt_run) begin
      r_rpt_cnt   <= 32'd0;
      r_rpt_phase <= 1'b0;
    end else if (w_rpt_wrap) begin
      r_rpt_cnt   <= 32'd0;
      r_rpt_phase <= 1'b1;
    end else begin
      r_rpt_cnt   <= r_rpt_cnt + 32'd1;
    end
  end
`else
  logic w_unused_rpt;
  assign w_unused_rpt = ^{HOLD_CYCLES, REPEAT_CYCLES};
  assign w_gap        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_arb    <= ARB_FREE;
      r_field  <= 4'd0;
      en_count <= 4'd0;
      enUP     <= 1'b0;
      enDOWN   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_arb    <= w_arb_nx;
      r_field  <= w_field_nx;
      en_count <= (w_state_nx == ST_EDIT) ? w_field_nx : 4'd0;
      enUP     <= (w_state_nx == ST_EDIT) && (w_arb_nx == ARB_UP) && !w_gap;
      enDOWN   <= (w_state_nx == ST_EDIT) && (w_arb_nx == ARB_DOWN) && !w_gap;
    end
  end

endmodule
`default_nettype wire
